// File: rtl/im_loader.sv
// Instruction-memory program loader. Takes a valid/ready byte stream and packs
// it big-endian into 32-bit words. Each word is written at byte address
// word_idx*4, and an XOR checksum of the image is kept. The CPU is held until
// a complete image has been loaded.
module im_loader #(
  parameter int NMEM  = 20,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             im_wr_en,
  output logic [31:0]      im_wr_addr,
  output logic [31:0]      im_wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [31:0]      checksum
);

  localparam int IDX_W = $clog2(NMEM) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       byte_cnt;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      sr;
  logic             len_ok;
  logic             last_word;
  logic [31:0]      next_word;

  // A requested length is legal when it is non-zero and fits in memory
  always_comb begin
    len_ok    = (len != '0) && (32'(len) <= 32'(NMEM));
    last_word = (32'(word_idx) == (32'(len_q) - 32'd1));
    next_word = {sr[23:0], in_data};
  end

  // Bytes are accepted only while assembling a word; this is decoded from state alone
  assign in_ready = (state == S_LOAD);

  // Loader FSM with registered memory-write and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      len_q      <= '0;
      byte_cnt   <= '0;
      word_idx   <= '0;
      sr         <= '0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      checksum   <= '0;
    end else begin
      im_wr_en <= 1'b0;
      case (state)
        // start is handled the same way from every resting state
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            if (len_ok) begin
              len_q    <= len;
              byte_cnt <= '0;
              word_idx <= '0;
              checksum <= '0;
              err      <= 1'b0;
              state    <= S_LOAD;
            end else begin
              err   <= 1'b1;
              state <= S_ERROR;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            sr       <= next_word;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_wr_en   <= 1'b1;
              im_wr_data <= next_word;
              im_wr_addr <= 32'({word_idx, 2'b00});
              state      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          checksum <= checksum ^ im_wr_data;
          if (last_word) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= S_DONE;
          end else begin
            word_idx <= word_idx + IDX_W'(1);
            state    <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
